// File: rtl/seven_seg_pkg.sv
// Shared seven-segment definitions: segment patterns (bit0=a .. bit6=g), reader FSM states, strobe helpers.
// Used by both the display driver and the display reader.
package seven_seg_pkg;

  localparam int unsigned SEG_W      = 7;
  localparam int unsigned CODE_W     = 4;
  localparam int unsigned CNT_W      = 4;
  localparam int unsigned IDX_W      = 3;
  localparam int unsigned MAX_DIGITS = 8;

  localparam logic [SEG_W-1:0] SEG_0     = 7'b0111111;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b1011011;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b1001111;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b1100110;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b1101101;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b1111101;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b0000111;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b1111111;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b1101111;
  localparam logic [SEG_W-1:0] SEG_A     = 7'b1110111;
  localparam logic [SEG_W-1:0] SEG_B     = 7'b1111100;
  localparam logic [SEG_W-1:0] SEG_C     = 7'b0111001;
  localparam logic [SEG_W-1:0] SEG_D     = 7'b1011110;
  localparam logic [SEG_W-1:0] SEG_E     = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_F     = 7'b1110001;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } rd_state_e;

  // Index of the set bit of a one-hot strobe (zero when no bit is set).
  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [MAX_DIGITS-1:0] sel);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < MAX_DIGITS; i++) begin
      if (sel[i]) idx = idx | IDX_W'(i);
    end
    return idx;
  endfunction

  function automatic logic is_one_hot(input logic [MAX_DIGITS-1:0] v);
    return (v != '0) && ((v & (v - MAX_DIGITS'(1))) == '0);
  endfunction

endpackage

// File: rtl/seven_segment_reader_if.sv
// Display bus sampled by the reader plus the recovered-digit outputs it produces.
interface seven_segment_reader_if #(
  parameter int unsigned NUM_DIGITS = 4
);
  import seven_seg_pkg::*;

  logic [SEG_W-1:0]           seg_in;
  logic [NUM_DIGITS-1:0]      dig_sel;
  logic [CODE_W*NUM_DIGITS-1:0] digits_out;
  logic [NUM_DIGITS-1:0]      digit_valid;
  logic                       upd_pulse;
  logic [IDX_W-1:0]           upd_idx;
  logic                       err_pulse;

  modport master (
    output seg_in, dig_sel,
    input  digits_out, digit_valid, upd_pulse, upd_idx, err_pulse
  );

  modport slave (
    input  seg_in, dig_sel,
    output digits_out, digit_valid, upd_pulse, upd_idx, err_pulse
  );

endinterface

// File: rtl/seven_segment_pattern_decode.sv
// Combinational map from a 7-segment pattern back to its 4-bit code.
// Hex letters A..F are decoded only when SEG_READER_HEX_EN is defined.
module seven_segment_pattern_decode
  import seven_seg_pkg::*;
(
  input  logic [SEG_W-1:0]  pattern,
  output logic [CODE_W-1:0] code,
  output logic              is_numeral,
  output logic              is_blank
);

  always_comb begin
    code       = '0;
    is_numeral = 1'b0;
    is_blank   = 1'b0;
    case (pattern)
      SEG_0:     begin code = 4'h0; is_numeral = 1'b1; end
      SEG_1:     begin code = 4'h1; is_numeral = 1'b1; end
      SEG_2:     begin code = 4'h2; is_numeral = 1'b1; end
      SEG_3:     begin code = 4'h3; is_numeral = 1'b1; end
      SEG_4:     begin code = 4'h4; is_numeral = 1'b1; end
      SEG_5:     begin code = 4'h5; is_numeral = 1'b1; end
      SEG_6:     begin code = 4'h6; is_numeral = 1'b1; end
      SEG_7:     begin code = 4'h7; is_numeral = 1'b1; end
      SEG_8:     begin code = 4'h8; is_numeral = 1'b1; end
      SEG_9:     begin code = 4'h9; is_numeral = 1'b1; end
`ifdef SEG_READER_HEX_EN
      SEG_A:     begin code = 4'hA; is_numeral = 1'b1; end
      SEG_B:     begin code = 4'hB; is_numeral = 1'b1; end
      SEG_C:     begin code = 4'hC; is_numeral = 1'b1; end
      SEG_D:     begin code = 4'hD; is_numeral = 1'b1; end
      SEG_E:     begin code = 4'hE; is_numeral = 1'b1; end
      SEG_F:     begin code = 4'hF; is_numeral = 1'b1; end
`endif
      SEG_BLANK: is_blank = 1'b1;
      default:   ;
    endcase
  end

endmodule

// File: rtl/seven_segment_reader.sv
// Samples a multiplexed seven-segment bus, debounces each strobed digit and holds its recovered code.
// Optional SEG_READER_HEX_EN (in the decoder) adds hex letters A..F.
module seven_segment_reader
  import seven_seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned STABLE_CNT = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  seven_segment_reader_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CNT);

  logic [SEG_W-1:0]      seg_q;
  logic [NUM_DIGITS-1:0] sel_q;
  rd_state_e             state_q, state_n;
  logic [CNT_W-1:0]      cnt_q, cnt_n;

  logic                  changed_c;
  logic                  in_one_hot_c;
  logic                  capture_c;

  logic [CODE_W-1:0]     dec_code;
  logic                  dec_numeral;
  logic                  dec_blank;

  logic [NUM_DIGITS-1:0][CODE_W-1:0] digits_q;
  logic [NUM_DIGITS-1:0] valid_q;
  logic                  upd_q;
  logic                  err_q;
  logic [IDX_W-1:0]      idx_q;

  // Single input register stage; sources must already be synchronous to clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q <= '0;
      sel_q <= '0;
    end else begin
      seg_q <= bus.seg_in;
      sel_q <= bus.dig_sel;
    end
  end

  // A sample is "unchanged" when the value about to be registered equals the held one.
  assign changed_c    = (bus.seg_in != seg_q) || (bus.dig_sel != sel_q);
  assign in_one_hot_c = is_one_hot(MAX_DIGITS'(bus.dig_sel));
  assign capture_c    = (state_q == TRACK) && (cnt_q == CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    if (!in_one_hot_c) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_n = TRACK;
          cnt_n   = CNT_W'(1);
        end
        TRACK: begin
          if (changed_c) begin
            cnt_n = CNT_W'(1);
          end else if (cnt_q == CNT_MAX) begin
            state_n = LOCKED;
          end else begin
            cnt_n = cnt_q + CNT_W'(1);
          end
        end
        LOCKED: begin
          if (changed_c) begin
            state_n = TRACK;
            cnt_n   = CNT_W'(1);
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      endcase
    end
  end

  seven_segment_pattern_decode u_decode (
    .pattern    (seg_q),
    .code       (dec_code),
    .is_numeral (dec_numeral),
    .is_blank   (dec_blank)
  );

  // Capture writes only the strobed digit; illegal patterns leave it untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits_q <= '0;
      valid_q  <= '0;
      upd_q    <= 1'b0;
      err_q    <= 1'b0;
      idx_q    <= '0;
    end else begin
      upd_q <= capture_c;
      err_q <= capture_c && !dec_numeral && !dec_blank;
      if (capture_c) idx_q <= onehot_to_idx(MAX_DIGITS'(sel_q));
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        if (capture_c && sel_q[i]) begin
          if (dec_numeral) begin
            digits_q[i] <= dec_code;
            valid_q[i]  <= 1'b1;
          end else if (dec_blank) begin
            digits_q[i] <= '0;
            valid_q[i]  <= 1'b0;
          end
        end
      end
    end
  end

  assign bus.digits_out  = digits_q;
  assign bus.digit_valid = valid_q;
  assign bus.upd_pulse   = upd_q;
  assign bus.upd_idx     = idx_q;
  assign bus.err_pulse   = err_q;

endmodule

// File: tb/tb_seven_segment_reader.sv
// Self-checking bench for seven_segment_reader: vector table for digit state, scoreboard queue for capture pulses.
module tb_seven_segment_reader;

  localparam int unsigned ND = 4;
  localparam int unsigned SC = 3;

`ifdef SEG_READER_HEX_EN
  localparam bit HEX = 1'b1;
`else
  localparam bit HEX = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seven_segment_reader_if #(.NUM_DIGITS(ND)) bus ();

  seven_segment_reader #(.NUM_DIGITS(ND), .STABLE_CNT(SC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [3:0]  sel;
    logic [6:0]  seg;
    int          dwell;
    bit          pulse;
    logic [2:0]  idx;
    bit          err;
    logic [15:0] digits;
    logic [3:0]  valid;
  } vec_t;

  typedef struct {
    int         due;
    logic [2:0] idx;
    bit         err;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Pulse monitor: every upd_pulse must match the head of the scoreboard in cycle, index and error flag.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (bus.upd_pulse) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL upd_pulse: unexpected pulse cycle %0d idx=%0d err=%0b, expected none",
                   cyc, bus.upd_idx, bus.err_pulse);
        end else begin
          e = sb.pop_front();
          if (e.due != cyc || e.idx !== bus.upd_idx || e.err !== bus.err_pulse) begin
            errors++;
            $display("FAIL upd_pulse: got cycle %0d idx=%0d err=%0b expected cycle %0d idx=%0d err=%0b",
                     cyc, bus.upd_idx, bus.err_pulse, e.due, e.idx, e.err);
          end
        end
      end else begin
        if (bus.err_pulse) begin
          checks++;
          errors++;
          $display("FAIL err_pulse: got 1 without upd_pulse at cycle %0d expected 0", cyc);
        end
        if (sb.size() != 0 && sb[0].due < cyc) begin
          checks++;
          errors++;
          $display("FAIL upd_pulse: got none expected pulse at cycle %0d idx=%0d", sb[0].due, sb[0].idx);
          void'(sb.pop_front());
        end
      end
    end
  end

  // Called on a falling edge; holds the inputs for exactly v.dwell rising edges.
  task automatic apply(input vec_t v, input int n);
    bus.dig_sel = v.sel;
    bus.seg_in  = v.seg;
    if (v.pulse) sb.push_back('{due: cyc + int'(SC) + 1, idx: v.idx, err: v.err});
    repeat (v.dwell) @(negedge clk);
    chk($sformatf("vec%0d digits_out", n), 32'(bus.digits_out), 32'(v.digits));
    chk($sformatf("vec%0d digit_valid", n), 32'(bus.digit_valid), 32'(v.valid));
  endtask

  task automatic add(input logic [3:0] sel, input logic [6:0] seg, input int dwell, input bit pulse,
                     input logic [2:0] idx, input bit err, input logic [15:0] digits, input logic [3:0] valid);
    vecs.push_back('{sel: sel, seg: seg, dwell: dwell, pulse: pulse, idx: idx, err: err,
                     digits: digits, valid: valid});
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " digits_out"}, 32'(bus.digits_out), 32'h0);
    chk({tag, " digit_valid"}, 32'(bus.digit_valid), 32'h0);
    chk({tag, " upd_pulse"}, 32'(bus.upd_pulse), 32'h0);
    chk({tag, " upd_idx"}, 32'(bus.upd_idx), 32'h0);
    chk({tag, " err_pulse"}, 32'(bus.err_pulse), 32'h0);
  endtask

  initial begin
    logic [15:0] d_hex;
    int          rel;
    bus.dig_sel = '0;
    bus.seg_in  = '0;

    d_hex = HEX ? 16'h9A02 : 16'h9402;
    //    sel      seg         dwell pulse idx err digits               valid
    add(4'b0001, 7'b1001111, 10, 1, 3'd0, 0, 16'h0003,              4'b0001); // 3, one pulse only
    add(4'b0000, 7'b0000000,  2, 0, 3'd0, 0, 16'h0003,              4'b0001);
    add(4'b0001, 7'b1011011,  6, 1, 3'd0, 0, 16'h0002,              4'b0001); // scan 2,0,4,9
    add(4'b0010, 7'b0111111,  6, 1, 3'd1, 0, 16'h0002,              4'b0011);
    add(4'b0100, 7'b1100110,  6, 1, 3'd2, 0, 16'h0402,              4'b0111);
    add(4'b1000, 7'b1101111,  6, 1, 3'd3, 0, 16'h9402,              4'b1111);
    add(4'b0010, 7'b1101101,  2, 0, 3'd0, 0, 16'h9402,              4'b1111); // toggling pattern
    add(4'b0010, 7'b0000110,  2, 0, 3'd0, 0, 16'h9402,              4'b1111);
    add(4'b0010, 7'b1101101,  2, 0, 3'd0, 0, 16'h9402,              4'b1111);
    add(4'b0010, 7'b0000110,  2, 0, 3'd0, 0, 16'h9402,              4'b1111);
    add(4'b0110, 7'b1111111,  8, 0, 3'd0, 0, 16'h9402,              4'b1111); // two strobes
    add(4'b0010, 7'b1101101,  6, 1, 3'd1, 0, 16'h9452,              4'b1111);
    add(4'b0010, 7'b0000000,  6, 1, 3'd1, 0, 16'h9402,              4'b1101); // blank
    add(4'b0100, 7'b1110111,  6, 1, 3'd2, !HEX, d_hex,              4'b1101); // letter A
    add(4'b0001, 7'b0000110,  3, 1, 3'd0, 0, d_hex,                 4'b1101); // minimum dwell
    add(4'b0000, 7'b0000000,  4, 0, 3'd0, 0, {d_hex[15:4], 4'h1},   4'b1101);
    add(4'b0001, 7'b0000110,  5, 1, 3'd0, 0, {d_hex[15:4], 4'h1},   4'b1101); // returning strobe

    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;

    foreach (vecs[i]) apply(vecs[i], i);

    // Reset mid-dwell clears held digits at once; next capture needs a full run.
    bus.dig_sel = 4'b0001;
    bus.seg_in  = 7'b0000111;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rel = cyc;
    sb.push_back('{due: rel + int'(SC) + 1, idx: 3'd0, err: 1'b0});
    repeat (6) @(negedge clk);
    chk("post_reset digits_out", 32'(bus.digits_out), 32'h0007);
    chk("post_reset digit_valid", 32'(bus.digit_valid), 32'h1);

    bus.dig_sel = '0;
    repeat (6) @(negedge clk);
    while (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL upd_pulse: got none expected pulse at cycle %0d idx=%0d", sb[0].due, sb[0].idx);
      void'(sb.pop_front());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seven_segment_reader.md
# seven_segment_reader

Receive-side counterpart of the seven-segment display driver. Samples a time-multiplexed display bus (active-high segment lines plus a one-hot digit strobe) and debounces each digit's pattern. Maps each stable pattern back to its 4-bit binary code and holds the recovered value per digit. Used in display loop-back self-test and to read front-panel displays driven by external logic.

## Interface
- NUM_DIGITS, 4: number of multiplexed digits, 1..8.
- STABLE_CNT, 3: consecutive identical samples required before capture, 2..15.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- seg_in  in  7  segment lines, bit0=a .. bit6=g, active-high.
- dig_sel  in  NUM_DIGITS  digit strobe, one-hot, active-high.
- digits_out  out  4*NUM_DIGITS  recovered codes, digit i in bits [4i+3:4i].
- digit_valid  out  NUM_DIGITS  digit i currently holds a decoded numeral.
- upd_pulse  out  1  one-cycle strobe: a capture occurred.
- upd_idx  out  3  digit index of the capture flagged by upd_pulse.
- err_pulse  out  1  one-cycle strobe: captured pattern is not a legal code.

## Operation
- Pattern map (g..a):
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110.
  - 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111.
  - 0000000=blank.
- Input stage: seg_in and dig_sel are registered once, with no further synchronisation. Asynchronous sources must be synchronised upstream.
- FSM states:
  - IDLE: registered dig_sel not exactly one-hot (zero or multiple bits set). Run counter held at 0.
  - TRACK: one-hot strobe seen. Counter counts consecutive cycles in which both the registered strobe and the registered pattern are unchanged.
  - LOCKED: capture done. Remains here, with no further pulses, while strobe and pattern are unchanged.
- Transitions:
  - Any change of strobe or pattern goes to TRACK with counter=1, or to IDLE if the strobe is not one-hot.
  - TRACK with counter == STABLE_CNT performs a capture and goes to LOCKED.
- Capture on digit i:
  - Legal numeral: digits_out[i] = code, digit_valid[i]=1.
  - Blank: digits_out[i]=4'h0, digit_valid[i]=0.
  - Any other pattern: digits_out[i] and digit_valid[i] unchanged, err_pulse=1.
  - upd_pulse=1 and upd_idx=i in all three cases.
- The counter saturates at STABLE_CNT. Width is 4 bits.
- Digits not currently strobed keep their last captured value indefinitely.

## Timing
- Reset values: digits_out=0, digit_valid=0, upd_pulse=0, upd_idx=0, err_pulse=0. FSM in IDLE, counter 0, sample registers 0.
- Latency: inputs stable from rising edge 1 give the capture and pulses in the cycle following edge STABLE_CNT+1. With the default, that is the cycle after edge 4.
- upd_pulse and err_pulse are high for exactly one cycle per capture.
- A strobe dwell shorter than STABLE_CNT cycles produces no capture.
- Strobe and pattern changing in the same cycle count as a single restart.
- Reset asserted mid-run clears everything immediately, including held digits. The first capture after reset release needs a full STABLE_CNT run.
- A returning strobe with an unchanged pattern still re-captures after STABLE_CNT cycles, with a fresh upd_pulse.

## Configuration
- SEG_READER_HEX_EN defined: additionally decodes hex letters, all with digit_valid=1:
  - A=1110111→4'hA, b=1111100→4'hB, C=0111001→4'hC.
  - d=1011110→4'hD, E=1111001→4'hE, F=1110001→4'hF.
- SEG_READER_HEX_EN undefined: these six patterns are illegal and raise err_pulse.

## Structure
- Shared package seven_seg_pkg:
  - Segment pattern constants SEG_0..SEG_9, SEG_A..SEG_F, SEG_BLANK.
  - FSM state enum: IDLE, TRACK, LOCKED.
  - A one-hot-to-index function.
  - The driver side uses the same constants.
- One sub-module, seven_segment_pattern_decode. Purely combinational: 7-bit pattern in, 4-bit code, is_numeral and is_blank out. It contains the SEG_READER_HEX_EN conditional.

## Test plan
- Reset, then dig_sel=0001, seg_in=1001111 held 10 cycles → single upd_pulse with upd_idx=0 in the cycle after edge 4; digits_out[3:0]=3, digit_valid[0]=1.
- Scan 4 digits showing 2,0,4,9 with a 6-cycle dwell each → four upd_pulses; digits_out=16'h9402, digit_valid=1111.
- dig_sel=0010 with seg_in toggling every 2 cycles → no upd_pulse. dig_sel=0110 held → no upd_pulse and digit values unchanged.
- Digit 1 holding 5, then seg_in=0000000 stable → upd_pulse, digits_out[7:4]=0, digit_valid[1]=0.
- seg_in=1110111 stable on digit 2 → without SEG_READER_HEX_EN: err_pulse=1 and digit 2 unchanged; with it: digits_out[11:8]=4'hA and digit_valid[2]=1.
- rst_n pulsed low mid-dwell after digits are captured → all outputs 0 immediately; a new capture appears only after a full STABLE_CNT run.
